// File: rtl/dso_pkg.sv
// dso_pkg: shared constants, state type and helpers for the DSO capture
// controller.
//   DSO_DEPTH / DSO_AW / DSO_DW : default buffer depth, address width, sample width
//   state_t                     : capture/readout sequencer states
//   pre_fill()                  : number of pre-trigger samples for a given N
package dso_pkg;

  localparam int unsigned DSO_DEPTH = 512;
  localparam int unsigned DSO_AW    = 9;
  localparam int unsigned DSO_DW    = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_ARMED = 3'd2,
    ST_POST  = 3'd3,
    ST_DONE  = 3'd4,
    ST_READ  = 3'd5
  } state_t;

  // Pre-trigger sample count: the buffer holds depth-1-N samples before the
  // trigger sample and N after it.
  function automatic int unsigned pre_fill(input int unsigned depth,
                                           input int unsigned n);
    return depth - 1 - n;
  endfunction

endpackage

// File: rtl/dso_capture_ctrl.sv
// dso_capture_ctrl: sequences a single-port sample RAM as a circular
// pre/post-trigger capture buffer, then reads it back oldest-to-newest.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   arm, trig_pos       : (re)start a capture, post-trigger count N latched on arm
//   smpl_vld, smpl      : ADC sample strobe and data
//   trig                : trigger, honoured only in ARMED together with smpl_vld
//   rd_req              : readout request (one byte per request)
//   rd_vld/rd_data/rd_last : readout byte, one cycle after the request
//   capturing, done     : status (PRE/ARMED/POST, DONE/READ)
//   trig_addr           : RAM address of the trigger sample
//   ram_en/ram_we/ram_addr/ram_wdata/ram_rdata : RAM master interface
module dso_capture_ctrl
  import dso_pkg::*;
#(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned AW    = 9,
  parameter int unsigned DW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          arm,
  input  logic [AW-1:0] trig_pos,
  input  logic          smpl_vld,
  input  logic [DW-1:0] smpl,
  input  logic          trig,
  input  logic          rd_req,
  output logic          rd_vld,
  output logic [DW-1:0] rd_data,
  output logic          rd_last,
  output logic          capturing,
  output logic          done,
  output logic [AW-1:0] trig_addr,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  state_t        state;
  logic [AW-1:0] n_lat;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] pre_cnt;
  logic [AW-1:0] post_cnt;
  logic [AW-1:0] rd_cnt;
  logic [AW-1:0] fill_arm;
  logic [AW-1:0] fill_lat;
  logic [AW-1:0] wr_ptr_inc;
  logic          wr_en;
  logic          rd_en;
  logic          in_capture;
  logic          in_readout;

  assign fill_arm   = AW'(pre_fill(DEPTH, 32'(trig_pos)));
  assign fill_lat   = AW'(pre_fill(DEPTH, 32'(n_lat)));
  assign wr_ptr_inc = wr_ptr + AW'(1);

  assign in_capture = (state == ST_PRE) || (state == ST_ARMED) || (state == ST_POST);
  assign in_readout = (state == ST_DONE) || (state == ST_READ);

  assign capturing = in_capture;
  assign done      = in_readout;
  assign rd_data   = ram_rdata;

  // arm wins over everything: neither the sample nor a read request of the
  // arm cycle touches the RAM.
  always_comb begin
    wr_en     = smpl_vld && !arm && in_capture;
    rd_en     = rd_req && !arm && in_readout;
    ram_en    = wr_en || rd_en;
    ram_we    = wr_en;
    ram_addr  = '0;
    ram_wdata = '0;
    if (wr_en) begin
      ram_addr  = wr_ptr;
      ram_wdata = smpl;
    end else if (rd_en) begin
      ram_addr  = rd_ptr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      n_lat     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      pre_cnt   <= '0;
      post_cnt  <= '0;
      rd_cnt    <= '0;
      trig_addr <= '0;
      rd_vld    <= 1'b0;
      rd_last   <= 1'b0;
    end else begin
      rd_vld  <= rd_en;
      rd_last <= rd_en && (rd_cnt == AW'(DEPTH - 1));

      if (arm) begin
        n_lat   <= trig_pos;
        pre_cnt <= '0;
        state   <= (fill_arm == '0) ? ST_ARMED : ST_PRE;
      end else begin
        unique case (state)
          ST_PRE: begin
            if (smpl_vld) begin
              wr_ptr  <= wr_ptr_inc;
              pre_cnt <= pre_cnt + AW'(1);
              if ((pre_cnt + AW'(1)) == fill_lat) state <= ST_ARMED;
            end
          end
          ST_ARMED: begin
            if (smpl_vld) begin
              wr_ptr <= wr_ptr_inc;
              if (trig) begin
                trig_addr <= wr_ptr;
                post_cnt  <= n_lat;
                if (n_lat == '0) begin
                  // Readout starts at the post-write pointer: the oldest sample.
                  state  <= ST_DONE;
                  rd_ptr <= wr_ptr_inc;
                  rd_cnt <= '0;
                end else begin
                  state <= ST_POST;
                end
              end
            end
          end
          ST_POST: begin
            if (smpl_vld) begin
              wr_ptr   <= wr_ptr_inc;
              post_cnt <= post_cnt - AW'(1);
              if (post_cnt == AW'(1)) begin
                state  <= ST_DONE;
                rd_ptr <= wr_ptr_inc;
                rd_cnt <= '0;
              end
            end
          end
          ST_DONE, ST_READ: begin
            if (rd_req) begin
              rd_ptr <= rd_ptr + AW'(1);
              rd_cnt <= rd_cnt + AW'(1);
              state  <= (rd_cnt == AW'(DEPTH - 1)) ? ST_IDLE : ST_READ;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/dso_capture_ctrl.md
Name: dso_capture_ctrl

Overview:
- Sequences one 512x8 sample RAM as a circular pre/post-trigger capture buffer for the DSO channel.
- Writes qualified ADC samples continuously once armed, then accepts a trigger and stores a programmable number of post-trigger samples.
- After capture, serves oldest-to-newest readout to the host/UART side, one byte per request.
- Sits between the ADC/trigger logic and the RAM; it is the RAM's only master.

Parameters:
- DEPTH, 512, buffer entries; power of two.
- AW, 9, address width (log2 DEPTH).
- DW, 8, sample width.

Ports:
- clk  in  1  system clock; RAM is clocked by the same clk.
- rst_n  in  1  asynchronous active-low reset.
- arm  in  1  pulse; (re)starts a capture from any state.
- trig_pos  in  AW  post-trigger sample count N, latched on arm.
- smpl_vld  in  1  ADC sample strobe.
- smpl  in  DW  ADC sample.
- trig  in  1  trigger event; only honoured on a cycle with smpl_vld=1.
- rd_req  in  1  readout request, at most one per cycle.
- rd_vld  out  1  readout data valid.
- rd_data  out  DW  readout byte; equals ram_rdata, meaningful only when rd_vld=1.
- rd_last  out  1  with rd_vld on the 512th byte.
- capturing  out  1  high in PRE/ARMED/POST.
- done  out  1  high in DONE/READ.
- trig_addr  out  AW  RAM address of the trigger sample.
- ram_en, ram_we  out  1  RAM enables.
- ram_addr  out  AW  RAM address.
- ram_wdata  out  DW  RAM write data.
- ram_rdata  in  DW  RAM read data; valid 1 clk after the en cycle.

Behaviour:
- States: IDLE, PRE, ARMED, POST, DONE, READ. Reset -> IDLE.
- Reset values: all registers 0; rd_vld=0, rd_last=0, capturing=0, done=0, trig_addr=0, wr_ptr=0, rd_ptr=0, counters=0.
- ram_en/ram_we/ram_addr/ram_wdata are combinational from registered state plus smpl_vld/rd_req/smpl. They are 0 when inactive.
- arm (any state, highest priority):
  - latch N=trig_pos; wr_ptr unchanged; pre_cnt=0.
  - go to PRE, or directly to ARMED if 511-N==0.
  - A sample on the arm cycle is not written.
- PRE: each smpl_vld writes smpl at wr_ptr (en=1, we=1), wr_ptr++ (mod 512), pre_cnt++.
  - trig is ignored in PRE.
  - When pre_cnt reaches 511-N, go to ARMED (transition on the write that completes the count).
- ARMED: each smpl_vld writes and increments wr_ptr.
  - If trig=1 and smpl_vld=1 in the same cycle, that sample is the trigger sample: trig_addr<=wr_ptr, post_cnt<=N.
  - Then go to POST, or to DONE if N==0.
- POST: each smpl_vld writes and post_cnt--. The write taking post_cnt to 0 -> DONE.
  - trig is ignored in POST.
- Total samples in a completed capture = 511-N pre + 1 trigger + N post = 512.
  - The oldest sample is at the final wr_ptr.
- DONE: on entry rd_ptr<=wr_ptr, rd_cnt<=0. smpl_vld is ignored (no writes).
  - A rd_req drives en=1, we=0, addr=rd_ptr, then rd_ptr++ and rd_cnt++, and the state goes to READ.
- READ: each rd_req issues the next read.
  - rd_vld is registered: a request at cycle T gives rd_vld=1 at T+1, with rd_data=ram_rdata.
  - Back-to-back requests give back-to-back data.
  - The 512th accepted request (rd_cnt==511) sets rd_last with its data at T+1, then the state goes to IDLE.
  - Further rd_req are ignored.
- rd_req outside DONE/READ is ignored.
- Write and read never coincide, because the states are exclusive.
- wr_ptr and rd_ptr wrap 511->0 silently.
- A mid-readout arm aborts the readout. rd_vld for a request issued in the arm cycle is suppressed.
- Async reset mid-capture or mid-readout returns to IDLE immediately. RAM contents are undefined to the consumer.

Decomposition:
- Package dso_pkg:
  - state enum;
  - DEPTH/AW/DW constants;
  - PRE_FILL function (DEPTH-1-N).
- Single module, no sub-module. The pointer and counter logic is small enough to inline.

Test Plan:
- Reset, arm, N=255, continuous smpl_vld with smpl=incrementing byte from 0x00 (trig held high throughout):
  - trigger ignored until 256 pre samples are written;
  - the 257th write is the trigger (trig_addr=256);
  - DONE after 255 more writes.
- Readout after the previous scenario, rd_req every cycle:
  - 512 bytes, with rd_vld exactly 1 clk after each rd_req;
  - first byte = oldest sample;
  - rd_last on byte 512;
  - back to IDLE.
- N=0, trigger at first chance:
  - 511 pre samples, trigger sample is the last write;
  - DONE the cycle after the trigger write;
  - the final readout byte equals the trigger sample.
- N=511:
  - ARMED immediately after arm;
  - first qualified trig with smpl_vld captured;
  - trig without smpl_vld produces no state change.
- Abort cases:
  - arm during POST with post_cnt=100 -> back to PRE, pre_cnt=0, no DONE;
  - arm during READ -> rd_vld drops, done=0.
- Async reset asserted mid-POST -> all outputs 0 in the same cycle.
- rd_req in ARMED -> no ram_en.
- smpl_vld in DONE -> no ram_we.
